traffic_sensor_hub: RTL and testbench

Front-end conditioning stage for the intersection controller. It synchronizes raw roadside inputs: loop detectors, pedestrian push-buttons and bus priority transponders. It keeps running waiting-car counts per approach, latches debounced pedestrian requests until the controller serves them, and rate-limits bus priority. Its outputs drive the controller's load, car-count, pedestrian and bus inputs directly; the controller's state output feeds back to clear served requests.

---
 rtl/traffic_sensor_hub.sv | 141 ++++++++++++++
 tb/tb_traffic_sensor_hub.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_hub.sv
// Input conditioning for the intersection controller: synchronizes roadside
// detectors, counts waiting cars, latches pedestrian requests, limits bus priority.
module traffic_sensor_hub #(
    parameter int LOAD_PERIOD = 4,
    parameter int DEBOUNCE    = 3,
    parameter int BUS_MAX     = 40
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_arr_ns,
    input  logic       i_arr_ew,
    input  logic       i_dep_ns,
    input  logic       i_dep_ew,
    input  logic       i_btn_ns,
    input  logic       i_btn_ew,
    input  logic       i_bus_ns,
    input  logic       i_bus_ew,
    input  logic [3:0] i_state,
    output logic       o_load,
    output logic [7:0] o_cars_ns,
    output logic [7:0] o_cars_ew,
    output logic       o_ped_ns,
    output logic       o_ped_ew,
    output logic       o_bus_ns,
    output logic       o_bus_ew
);

    localparam int TW = $clog2(LOAD_PERIOD);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int BW = $clog2(BUS_MAX + 1);

    // Bit layout per direction d (0 = NS, 1 = EW): arr d, dep 2+d, btn 4+d, bus 6+d.
    logic [7:0] raw;
    assign raw = {i_bus_ew, i_bus_ns, i_btn_ew, i_btn_ns,
                  i_dep_ew, i_dep_ns, i_arr_ew, i_arr_ns};

    logic [7:0]          s1_q, s1_d, s2_q, s2_d;
    logic [3:0]          prev_q, prev_d;
    logic [1:0][7:0]     cars_q, cars_d;
    logic [1:0][DW-1:0]  dbc_q, dbc_d;
    logic [1:0]          ped_q, ped_d;
    logic [1:0][BW-1:0]  hold_q, hold_d;
    logic [1:0]          expired_q, expired_d;
    logic [1:0]          bus_q, bus_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic                load_q, load_d;

    logic [3:0] rise;
    logic [1:0] served;
    logic [1:0] ped_set;

    always_comb begin
        s1_d      = raw;
        s2_d      = s1_q;
        prev_d    = s2_q[3:0];
        rise      = s2_q[3:0] & ~prev_q;
        served[0] = (i_state == 4'd1) || (i_state == 4'd2);
        served[1] = (i_state == 4'd5) || (i_state == 4'd6);

        cars_d    = cars_q;
        dbc_d     = '0;
        ped_d     = '0;
        ped_set   = '0;
        hold_d    = '0;
        expired_d = '0;
        bus_d     = '0;

        for (int d = 0; d < 2; d++) begin
            // Simultaneous arrival and departure cancel out.
            if (rise[d] && !rise[2+d] && cars_q[d] != 8'hFF) begin
                cars_d[d] = cars_q[d] + 8'd1;
            end else if (!rise[d] && rise[2+d] && cars_q[d] != 8'h00) begin
                cars_d[d] = cars_q[d] - 8'd1;
            end

            if (i_enable) begin
                // Saturating at DEBOUNCE makes a held button set the latch only once.
                if (s2_q[4+d]) begin
                    dbc_d[d] = (dbc_q[d] == DW'(DEBOUNCE)) ? dbc_q[d] : dbc_q[d] + DW'(1);
                end
                ped_set[d] = s2_q[4+d] && (dbc_q[d] == DW'(DEBOUNCE - 1));
                ped_d[d]   = served[d] ? 1'b0 : (ped_q[d] | ped_set[d]);

                if (s2_q[6+d]) begin
                    hold_d[d]    = bus_q[d] ? hold_q[d] + BW'(1) : hold_q[d];
                    expired_d[d] = expired_q[d] |
                                   (bus_q[d] && (hold_q[d] == BW'(BUS_MAX - 1)));
                    bus_d[d]     = ~expired_d[d];
                end
            end
        end

        tick_d = '0;
        load_d = 1'b0;
        if (i_enable) begin
            if (tick_q == TW'(LOAD_PERIOD - 1)) begin
                load_d = 1'b1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            cars_q    <= '0;
            dbc_q     <= '0;
            ped_q     <= '0;
            hold_q    <= '0;
            expired_q <= '0;
            bus_q     <= '0;
            tick_q    <= '0;
            load_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
            cars_q    <= cars_d;
            dbc_q     <= dbc_d;
            ped_q     <= ped_d;
            hold_q    <= hold_d;
            expired_q <= expired_d;
            bus_q     <= bus_d;
            tick_q    <= tick_d;
            load_q    <= load_d;
        end
    end

    assign o_load    = load_q;
    assign o_cars_ns = cars_q[0];
    assign o_cars_ew = cars_q[1];
    assign o_ped_ns  = ped_q[0];
    assign o_ped_ew  = ped_q[1];
    assign o_bus_ns  = bus_q[0];
    assign o_bus_ew  = bus_q[1];

endmodule

// File: tb/tb_traffic_sensor_hub.sv
// Directed bench for traffic_sensor_hub: car counting, debounce, bus limit,
// load cadence, enable gating and asynchronous reset.
module tb_traffic_sensor_hub;

    localparam int ARR_NS = 0, ARR_EW = 1, DEP_NS = 2, DEP_EW = 3;
    localparam int BTN_NS = 4, BTN_EW = 5, BUS_NS = 6, BUS_EW = 7;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] raw;
    logic [3:0] state;
    logic       o_load;
    logic [7:0] o_cars_ns, o_cars_ew;
    logic       o_ped_ns, o_ped_ew, o_bus_ns, o_bus_ew;
    logic [20:0] outs;

    int checks   = 0;
    int failures = 0;
    logic [0:0] exp_q[$];

    assign outs = {o_load, o_cars_ns, o_cars_ew, o_ped_ns, o_ped_ew, o_bus_ns, o_bus_ew};

    traffic_sensor_hub #(.LOAD_PERIOD(4), .DEBOUNCE(3), .BUS_MAX(40)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enable (enable),
        .i_arr_ns (raw[ARR_NS]),
        .i_arr_ew (raw[ARR_EW]),
        .i_dep_ns (raw[DEP_NS]),
        .i_dep_ew (raw[DEP_EW]),
        .i_btn_ns (raw[BTN_NS]),
        .i_btn_ew (raw[BTN_EW]),
        .i_bus_ns (raw[BUS_NS]),
        .i_bus_ew (raw[BUS_EW]),
        .i_state  (state),
        .o_load   (o_load),
        .o_cars_ns(o_cars_ns),
        .o_cars_ew(o_cars_ew),
        .o_ped_ns (o_ped_ns),
        .o_ped_ew (o_ped_ew),
        .o_bus_ns (o_bus_ns),
        .o_bus_ew (o_bus_ew)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, leaving time 1 unit after the last rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int idx, input int n);
        repeat (n) begin
            raw[idx] = 1'b1;
            step(1);
            raw[idx] = 1'b0;
            step(1);
        end
    endtask

    initial begin
        int first_hi, last_hi, hi_cnt;
        rst_n  = 1'b0;
        enable = 1'b0;
        raw    = '0;
        state  = 4'd0;
        step(2);
        check("reset_state", outs, 0);
        rst_n = 1'b1;

        // Car counting and three-edge latency
        raw[ARR_NS] = 1'b1;
        step(1);
        raw[ARR_NS] = 1'b0;
        step(1);
        check("arr_lat_2edges", o_cars_ns, 0);
        step(1);
        check("arr_lat_3edges", o_cars_ns, 1);
        pulse(ARR_NS, 4);
        step(3);
        check("arr_five", o_cars_ns, 5);
        raw[DEP_NS] = 1'b1;
        step(1);
        raw[DEP_NS] = 1'b0;
        step(1);
        check("dep_lat_2edges", o_cars_ns, 5);
        step(1);
        check("dep_lat_3edges", o_cars_ns, 4);
        pulse(DEP_NS, 1);
        step(3);
        check("cars_ns_three", o_cars_ns, 3);
        check("cars_ew_zero", o_cars_ew, 0);

        // Saturation at both ends and simultaneous arrival/departure
        pulse(ARR_EW, 300);
        step(3);
        check("cars_ew_sat_255", o_cars_ew, 255);
        pulse(DEP_EW, 1);
        step(3);
        check("cars_ew_254", o_cars_ew, 254);
        pulse(DEP_NS, 6);
        step(3);
        check("cars_ns_floor_0", o_cars_ns, 0);
        pulse(ARR_NS, 7);
        step(3);
        check("cars_ns_seven", o_cars_ns, 7);
        raw[ARR_NS] = 1'b1;
        raw[DEP_NS] = 1'b1;
        step(1);
        raw[ARR_NS] = 1'b0;
        raw[DEP_NS] = 1'b0;
        step(4);
        check("cars_ns_both_same", o_cars_ns, 7);

        // Pedestrian debounce and service clearing
        enable = 1'b1;
        pulse(BTN_NS, 2);
        step(4);
        check("ped_bounce_ignored", o_ped_ns, 0);
        raw[BTN_NS] = 1'b1;
        step(4);
        check("ped_before_debounce", o_ped_ns, 0);
        step(1);
        check("ped_debounced_set", o_ped_ns, 1);
        state = 4'd1;
        step(1);
        check("ped_served_clear", o_ped_ns, 0);
        step(5);
        check("ped_served_held", o_ped_ns, 0);
        state = 4'd0;
        step(3);
        check("ped_no_reset_held", o_ped_ns, 0);
        raw[BTN_NS] = 1'b0;
        step(3);
        raw[BTN_EW] = 1'b1;
        step(5);
        check("ped_ew_set", o_ped_ew, 1);
        check("ped_ns_untouched", o_ped_ns, 0);
        state = 4'd6;
        step(1);
        check("ped_ew_served", o_ped_ew, 0);
        raw[BTN_EW] = 1'b0;
        state = 4'd2;
        raw[BTN_NS] = 1'b1;
        step(8);
        check("ped_clear_beats_set", o_ped_ns, 0);
        raw[BTN_NS] = 1'b0;
        state = 4'd0;
        step(3);

        // Bus hold limit
        raw[BUS_EW] = 1'b1;
        first_hi = 0;
        last_hi  = 0;
        hi_cnt   = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1);
            if (o_bus_ew) begin
                hi_cnt++;
                if (first_hi == 0) first_hi = i;
                last_hi = i;
            end
        end
        check("bus_high_cycles", hi_cnt, 40);
        check("bus_first_cycle", first_hi, 3);
        check("bus_last_cycle", last_hi, 42);
        check("bus_ns_idle", o_bus_ns, 0);
        raw[BUS_EW] = 1'b0;
        step(4);
        check("bus_released", o_bus_ew, 0);
        raw[BUS_EW] = 1'b1;
        step(2);
        check("bus_rereq_early", o_bus_ew, 0);
        step(1);
        check("bus_rereq_high", o_bus_ew, 1);
        raw[BUS_EW] = 1'b0;
        step(4);

        // Load cadence from a fresh enable
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        for (int i = 1; i <= 20; i++) exp_q.push_back(1'((i % 4) == 0));
        for (int i = 1; i <= 20; i++) begin
            step(1);
            check($sformatf("load_cadence_%0d", i), o_load, exp_q.pop_front());
        end

        // Enable drop at cycle 10 gates load, ped and bus
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        raw[BTN_NS] = 1'b1;
        raw[BUS_NS] = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            check($sformatf("load_pre_drop_%0d", i), o_load, ((i % 4) == 0) ? 1 : 0);
        end
        check("ped_before_drop", o_ped_ns, 1);
        check("bus_before_drop", o_bus_ns, 1);
        enable = 1'b0;
        for (int i = 10; i <= 14; i++) begin
            step(1);
            check($sformatf("load_dropped_%0d", i), o_load, 0);
        end
        check("ped_forced_off", o_ped_ns, 0);
        check("bus_forced_off", o_bus_ns, 0);
        raw = '0;
        step(3);

        // Asynchronous reset between edges
        enable = 1'b1;
        raw[BUS_EW] = 1'b1;
        raw[BTN_NS] = 1'b1;
        step(6);
        check("pre_rst_ped", o_ped_ns, 1);
        check("pre_rst_bus", o_bus_ew, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", outs, 0);
        raw = '0;
        step(1);
        check("rst_held_outputs", outs, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check($sformatf("load_after_rst_%0d", i), o_load, (i == 4 || i == 8) ? 1 : 0);
        end
        check("cars_after_rst", {o_cars_ns, o_cars_ew}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
